uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between two byte-stream requesters (e.g. APB register writes and a DMA/status engine). It grants the transmitter to one requester at a time for a whole burst and converts each accepted byte into a one-cycle `wr_uart` write strobe. It respects the transmitter's `tx_full` back-pressure and releases a stalled grant after a programmable idle timeout. It sits between the requesters and the `uart` write port (`wr_uart`, `w_data`, `tx_full`).

## Interface
- `BITWIDTH`, 8, data byte width
- `MAX_BURST`, 16, maximum beats per grant before forced release (>=1)
- `IDLE_TIMEOUT`, 32, cycles a granted requester may hold `valid` low before the grant is revoked (>=1)

- `PCLK` in 1: single clock; all logic is rising-edge
- `PRESETN` in 1: reset, synchronous and active-low
- `req0_valid` in 1: requester 0 has a byte
- `req0_data` in BITWIDTH: requester 0 byte
- `req0_last` in 1: byte is the final beat of the burst
- `req0_ready` out 1: byte accepted when `valid & ready`
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same as requester 0, for requester 1
- `tx_full` in 1: UART TX FIFO full; no write may be issued while high
- `wr_uart` out 1: one-cycle write strobe to the UART
- `w_data` out BITWIDTH: byte presented with `wr_uart`
- `grant` out 2: one-hot owner (`01` = req0, `10` = req1, `00` = none)
- `busy` out 1: high whenever `grant != 00`

## Operation
- FSM states: IDLE, GRANT0, GRANT1. `grant` and `busy` decode directly from the state.
- `last_grant` register: records the most recently served requester.
- **IDLE transitions:**
  - Only `req0_valid` high: go to GRANT0.
  - Only `req1_valid` high: go to GRANT1.
  - Both high: grant the requester that is not `last_grant`.
  - Neither high: stay in IDLE.
- **Entering GRANTn:**
  - `last_grant` updates to n.
  - `beat_cnt` and `idle_cnt` clear to 0.
- **Ready rule in GRANTn:** `reqn_ready = !tx_full & !wr_uart` (combinational). The other requester's ready is 0.
  - Because ready is gated by `!wr_uart`, consecutive writes are spaced by at least one cycle. This allows `tx_full` to reflect the previous write.
- **Accepted beat** (`reqn_valid & reqn_ready`):
  - Next cycle, `wr_uart` = 1 and `w_data` = the accepted byte.
  - `beat_cnt` increments.
  - `idle_cnt` clears.
- **Release to IDLE** happens on any of:
  - an accepted beat with `last` = 1;
  - an accepted beat that brings `beat_cnt` to `MAX_BURST`;
  - `idle_cnt` reaching `IDLE_TIMEOUT`.
- **Idle counter:** `idle_cnt` increments each cycle in GRANTn while `reqn_valid` = 0. It holds (does not clear) while valid is high but `tx_full` is blocking.
- **Non-owner:** `valid` on the non-owning requester is ignored until IDLE.
- **Counter widths:** `beat_cnt` is clog2(MAX_BURST+1) bits and `idle_cnt` is clog2(IDLE_TIMEOUT+1) bits. Neither may wrap.
- **`w_data`:** holds its last value when `wr_uart` = 0.
- **Reset values:**
  - State = IDLE, `grant` = 00, `busy` = 0.
  - `wr_uart` = 0, `w_data` = 0, both readies = 0.
  - Counters = 0, `last_grant` = req1, so req0 wins the first tie.
- **Reset mid-burst:** the burst is abandoned. No strobe is issued in the cycle after reset; the requester must restart its burst.

## Timing
- **Arbitration latency:** `valid` seen in IDLE at cycle t gives `grant` at t+1. The earliest accept is at t+1, with `wr_uart` at t+2.
- **Throughput:** at most one byte every 2 cycles while `tx_full` = 0.
- **Last beat:** a last beat accepted at cycle c gives IDLE at c+1 and the next grant at c+2. That is one dead cycle between bursts.
- **`tx_full`:** sampled combinationally in the cycle of acceptance. It has no effect on an already-registered `wr_uart`.
- **`tx_full` and timeout together:** `tx_full` high with `valid` high never triggers the timeout.
- **Simultaneous last and `MAX_BURST`:** a single release.
- **Simultaneous release and the other requester's valid:** the other requester is granted in the next IDLE cycle (round-robin).

## Test plan
- **Single requester:** reset, then req0 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3) with `tx_full` = 0. Expect `grant` = 01 one cycle after valid, `wr_uart` pulses every 2 cycles carrying A1, A2, A3, and `grant` = 00 the cycle after the A3 accept.
- **Round-robin tie:** both valid continuously with 2-byte bursts (req0: 0x10, 0x11; req1: 0x20, 0x21). Expect `w_data` sequence 10, 11, 20, 21, 10, 11, … with the grant alternating 01/10 and one idle cycle between bursts.
- **Back-pressure:** `tx_full` = 1 for 5 cycles mid-burst. Expect `req0_ready` = 0, no `wr_uart`, and no timeout. After `tx_full` drops, the next byte is written and no bytes are lost or duplicated.
- **`MAX_BURST`:** `MAX_BURST` = 4, req0 streams 6 bytes with last only on the 6th, and req1 is valid. Expect the grant to release after the 4th byte, req1's burst to be served next, and req0 to resume with its 5th byte.
- **Timeout:** `IDLE_TIMEOUT` = 8, req1 is granted, sends 1 byte, then drops valid. Expect `grant` = 00 exactly 8 cycles after valid falls, and req0 to be granted immediately after.
- **Reset mid-burst:** assert `PRESETN` = 0 for 1 cycle during a req1 burst. Expect all outputs at reset values on the next edge, no `wr_uart` in that cycle, and a tie after reset to go to req0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte-stream requesters.
// The owner keeps the grant for a whole burst, bounded by MAX_BURST beats and an idle timeout.
module uart_tx_arbiter #(
  parameter int BITWIDTH     = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic                req0_valid,
  input  logic [BITWIDTH-1:0] req0_data,
  input  logic                req0_last,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [BITWIDTH-1:0] req1_data,
  input  logic                req1_last,
  output logic                req1_ready,
  input  logic                tx_full,
  output logic                wr_uart,
  output logic [BITWIDTH-1:0] w_data,
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t              state;
  logic                last_grant;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [IDLE_W-1:0]   idle_cnt;

  logic                own_valid;
  logic [BITWIDTH-1:0] own_data;
  logic                own_last;
  logic                can_accept;
  logic                accept;
  logic [BEAT_W-1:0]   beat_next;
  logic                burst_done;
  logic                timed_out;

  // Ready is withheld in the cycle of a strobe so tx_full can catch up with the previous write.
  always_comb begin
    own_valid  = 1'b0;
    own_data   = '0;
    own_last   = 1'b0;
    case (state)
      GRANT0: begin
        own_valid = req0_valid;
        own_data  = req0_data;
        own_last  = req0_last;
      end
      GRANT1: begin
        own_valid = req1_valid;
        own_data  = req1_data;
        own_last  = req1_last;
      end
      default: ;
    endcase

    can_accept = PRESETN & ~tx_full & ~wr_uart;
    req0_ready = (state == GRANT0) & can_accept;
    req1_ready = (state == GRANT1) & can_accept;
    accept     = own_valid & (req0_ready | req1_ready);

    beat_next  = beat_cnt + 1'b1;
    burst_done = accept & (own_last | (beat_next == BEAT_W'(MAX_BURST)));
    timed_out  = (state != IDLE) & ~own_valid
               & (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state      <= IDLE;
      grant      <= 2'b00;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      idle_cnt   <= '0;
      wr_uart    <= 1'b0;
      w_data     <= '0;
    end else begin
      wr_uart <= accept;
      if (accept) begin
        w_data <= own_data;
      end

      case (state)
        IDLE: begin
          beat_cnt <= '0;
          idle_cnt <= '0;
          // On a tie, the requester not served most recently wins.
          if (req0_valid && (!req1_valid || last_grant)) begin
            state      <= GRANT0;
            grant      <= 2'b01;
            busy       <= 1'b1;
            last_grant <= 1'b0;
          end else if (req1_valid) begin
            state      <= GRANT1;
            grant      <= 2'b10;
            busy       <= 1'b1;
            last_grant <= 1'b1;
          end
        end

        GRANT0, GRANT1: begin
          if (accept) begin
            beat_cnt <= beat_next;
            idle_cnt <= '0;
          end else if (!own_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (burst_done || timed_out) begin
            state <= IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transaction-level arbitration model predicts
// grants, readies and the written byte stream; a monitor checks every DUT strobe.
module tb_uart_tx_arbiter;

  localparam int BW = 8;
  localparam int MB = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  logic          PCLK = 1'b0;
  logic          PRESETN;
  logic          req0_valid, req0_last, req0_ready;
  logic [BW-1:0] req0_data;
  logic          req1_valid, req1_last, req1_ready;
  logic [BW-1:0] req1_data;
  logic          tx_full;
  logic          wr_uart;
  logic [BW-1:0] w_data;
  logic [1:0]    grant;
  logic          busy;

  uart_tx_arbiter #(
    .BITWIDTH(BW),
    .MAX_BURST(MB),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETN(PRESETN),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_last(req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_last(req1_last),
    .req1_ready(req1_ready),
    .tx_full(tx_full),
    .wr_uart(wr_uart),
    .w_data(w_data),
    .grant(grant),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int testsRun = 0;
  int testsFailed = 0;

  beat_t         reqQ0[$];
  beat_t         reqQ1[$];
  int            holdCnt0 = 0;
  int            holdCnt1 = 0;
  bit            resetReq = 1'b1;
  bit            txFullReq = 1'b0;
  logic [BW-1:0] sbQ[$];

  // Reference model: who owns the transmitter and how long they have held it.
  int            owner = -1;
  int            lastServed = 1;
  int            beats = 0;
  int            idles = 0;
  bit            pendingWrite = 1'b0;
  logic [BW-1:0] expWdata = '0;
  bit            expReady0, expReady1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [1:0] expGrant();
    if (owner == 0) return 2'b01;
    if (owner == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void computeReady();
    expReady0 = PRESETN && owner == 0 && !tx_full && !pendingWrite;
    expReady1 = PRESETN && owner == 1 && !tx_full && !pendingWrite;
  endfunction

  // Advance the model by one clock using the inputs the bench drove this cycle.
  function automatic void modelStep();
    bit    acc;
    bit    ownValid;
    beat_t b;
    computeReady();
    if (!PRESETN) begin
      owner = -1; lastServed = 1; beats = 0; idles = 0;
      pendingWrite = 1'b0; expWdata = '0;
      sbQ.delete();
      return;
    end
    acc = 1'b0;
    b = '0;
    ownValid = (owner == 0) ? req0_valid : (owner == 1) ? req1_valid : 1'b0;
    if (owner == 0 && req0_valid && expReady0) begin
      acc = 1'b1; b = reqQ0.pop_front();
    end else if (owner == 1 && req1_valid && expReady1) begin
      acc = 1'b1; b = reqQ1.pop_front();
    end
    if (owner == -1) begin
      int pick;
      pick = -1;
      if (req0_valid && req1_valid) pick = (lastServed == 0) ? 1 : 0;
      else if (req0_valid) pick = 0;
      else if (req1_valid) pick = 1;
      if (pick != -1) begin
        owner = pick; lastServed = pick; beats = 0; idles = 0;
      end
    end else if (acc) begin
      sbQ.push_back(b.data);
      expWdata = b.data;
      beats++;
      idles = 0;
      if (b.last || beats == MB) owner = -1;
    end else if (!ownValid) begin
      idles++;
      if (idles == TO) owner = -1;
    end
    pendingWrite = acc;
  endfunction

  function automatic void pushBurst(input int n, input int len, input logic [BW-1:0] base,
                                    input bit withLast);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = base + BW'(i);
      b.last = withLast && (i == len - 1);
      if (n == 0) reqQ0.push_back(b);
      else reqQ1.push_back(b);
    end
  endfunction

  task automatic driveInputs(input bit randomMode);
    PRESETN = !resetReq;
    if (randomMode) begin
      tx_full = ($urandom_range(0, 3) == 0);
      if (reqQ0.size() == 0 && $urandom_range(0, 3) == 0)
        pushBurst(0, $urandom_range(1, 6), BW'($urandom), $urandom_range(0, 7) != 0);
      if (reqQ1.size() == 0 && $urandom_range(0, 3) == 0)
        pushBurst(1, $urandom_range(1, 6), BW'($urandom), $urandom_range(0, 7) != 0);
      if (holdCnt0 == 0 && $urandom_range(0, 15) == 0) holdCnt0 = $urandom_range(1, 12);
      if (holdCnt1 == 0 && $urandom_range(0, 15) == 0) holdCnt1 = $urandom_range(1, 12);
    end else begin
      tx_full = txFullReq;
    end
    if (holdCnt0 > 0) begin
      req0_valid = 1'b0; holdCnt0--;
    end else begin
      req0_valid = (reqQ0.size() > 0);
    end
    if (holdCnt1 > 0) begin
      req1_valid = 1'b0; holdCnt1--;
    end else begin
      req1_valid = (reqQ1.size() > 0);
    end
    req0_data = (reqQ0.size() > 0) ? reqQ0[0].data : '0;
    req0_last = (reqQ0.size() > 0) ? reqQ0[0].last : 1'b0;
    req1_data = (reqQ1.size() > 0) ? reqQ1[0].data : '0;
    req1_last = (reqQ1.size() > 0) ? reqQ1[0].last : 1'b0;
  endtask

  task automatic applyStimulus(input int cycles, input bit randomMode);
    for (int i = 0; i < cycles; i++) begin
      @(negedge PCLK);
      driveInputs(randomMode);
      #1;
      computeReady();
      checkOutput("req0_ready", {31'b0, req0_ready}, {31'b0, expReady0});
      checkOutput("req1_ready", {31'b0, req1_ready}, {31'b0, expReady1});
      @(posedge PCLK);
      modelStep();
    end
  endtask

  // Monitor: registered outputs against the model, strobes against the scoreboard.
  always @(negedge PCLK) begin
    checkOutput("grant", {30'b0, grant}, {30'b0, expGrant()});
    checkOutput("busy", {31'b0, busy}, {31'b0, owner != -1});
    checkOutput("wr_uart", {31'b0, wr_uart}, {31'b0, sbQ.size() != 0});
    if (sbQ.size() != 0) begin
      logic [BW-1:0] want;
      want = sbQ.pop_front();
      if (wr_uart) checkOutput("w_data_strobe", {24'b0, w_data}, {24'b0, want});
    end
    checkOutput("w_data_hold", {24'b0, w_data}, {24'b0, expWdata});
  end

  initial begin
    PRESETN = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    tx_full = 1'b0;

    resetReq = 1'b1;
    applyStimulus(3, 1'b0);
    resetReq = 1'b0;
    #1;
    checkOutput("reset_grant", {30'b0, grant}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_wr_uart", {31'b0, wr_uart}, 32'd0);
    checkOutput("reset_w_data", {24'b0, w_data}, 32'd0);

    // Single requester, three-byte burst.
    pushBurst(0, 3, 8'hA1, 1'b1);
    applyStimulus(12, 1'b0);

    // Round-robin tie with two-byte bursts.
    pushBurst(0, 2, 8'h10, 1'b1); pushBurst(0, 2, 8'h10, 1'b1);
    pushBurst(1, 2, 8'h20, 1'b1); pushBurst(1, 2, 8'h20, 1'b1);
    applyStimulus(30, 1'b0);

    // Back-pressure mid-burst.
    pushBurst(0, 5, 8'hB0, 1'b1);
    applyStimulus(3, 1'b0);
    txFullReq = 1'b1;
    applyStimulus(5, 1'b0);
    txFullReq = 1'b0;
    applyStimulus(15, 1'b0);

    // Burst longer than MAX_BURST with the other requester waiting.
    pushBurst(0, 6, 8'hC0, 1'b1);
    pushBurst(1, 2, 8'h70, 1'b1);
    holdCnt1 = 2;
    applyStimulus(35, 1'b0);

    // Owner goes quiet after one byte; the waiting requester takes over on timeout.
    pushBurst(1, 1, 8'h55, 1'b0);
    pushBurst(0, 1, 8'h66, 1'b1);
    holdCnt0 = 4;
    applyStimulus(25, 1'b0);

    // Reset in the middle of a req1 burst, then a tie.
    pushBurst(1, 4, 8'h30, 1'b1);
    applyStimulus(4, 1'b0);
    pushBurst(0, 2, 8'h40, 1'b1);
    resetReq = 1'b1;
    applyStimulus(1, 1'b0);
    resetReq = 1'b0;
    applyStimulus(25, 1'b0);

    // Randomised traffic with back-pressure, pauses and a reset in between.
    applyStimulus(1500, 1'b1);
    resetReq = 1'b1;
    applyStimulus(1, 1'b1);
    resetReq = 1'b0;
    applyStimulus(1500, 1'b1);

    @(negedge PCLK);
    #1;
    checkOutput("sb_drained", sbQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
